modaddsub_limb: RTL and testbench
=================================

MODADDSUB_LIMB -- requirements
Module: modaddsub_limb

Interface
REQ-001 Parameter WIDTH, default 381: operand/modulus/result width in bits.
REQ-002 Parameter LIMB, default 64: bits processed per cycle; NLIMBS = ceil(WIDTH/LIMB), giving 6 at the defaults.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 subtract  input  1  0 = (a+b) mod m, 1 = (a-b) mod m; latched with start.
REQ-007 in_a, in_b, in_m  input  WIDTH each  operands and modulus; latched with start.
REQ-008 out_read  input  1  consumer acknowledge of the result; honoured only in DONE.
REQ-009 result  output  WIDTH  reduced result; valid while done=1.
REQ-010 done  output  1  result valid.
REQ-011 busy  output  1  high in RUN and DONE.

Function
REQ-012 States SHALL be IDLE, RUN and DONE, with a limb counter idx running 0..NLIMBS-1.
REQ-013 IDLE with start=1 at an edge SHALL latch in_a, in_b, in_m and subtract, clear idx and both carry/borrow flags, and go to RUN.
REQ-014 Limbs SHALL be taken LSB first, with the top limb zero-padded above WIDTH.
REQ-015 Each RUN edge SHALL process limb idx with two chains in parallel.
- Chain 1: s = a ± b, using carry c1 (add) or borrow c1 (sub).
- Chain 2: t = s − m for add, or t = s + m for sub, using flag c2, fed by the chain-1 limb in the same cycle.
- Both the s and t limbs SHALL be stored.
REQ-016 Selection after the final limb (idx=NLIMBS-1) SHALL be:
- Add: result = t if (c1=1 or final c2 shows no borrow), else s.
- Sub: result = t if final c1 = borrow, else s.
REQ-017 After the final limb the block SHALL go to DONE, with result registered and done=1 from that edge.
REQ-018 Latency from the start edge to done high SHALL be exactly NLIMBS edges; throughput SHALL be one operation per NLIMBS+1+(cycles waiting for out_read).
REQ-019 In DONE, result and done SHALL hold stable until out_read=1 at an edge; that edge SHALL clear done, leave result unchanged, and go to IDLE.
REQ-020 start in RUN or DONE SHALL be ignored, with no effect on latched operands or the count.
REQ-021 out_read outside DONE SHALL be ignored.
REQ-022 A new start SHALL be accepted in the cycle after the out_read edge, not in the same edge.
REQ-023 Input and arithmetic rules:
- Inputs are required to satisfy a<m, b<m and m>1; otherwise the output is unspecified, but the FSM SHALL still complete.
- Results SHALL always lie in [0, m−1].
- a+b == m SHALL yield 0.
- a−b < 0 SHALL wrap by +m.
- a == b with subtract SHALL yield 0.
REQ-024 Internal sums SHALL be held at LIMB+1 bits per limb; no intermediate value wider than NLIMBS*LIMB+1 bits.
REQ-025 Changes on in_a, in_b, in_m or subtract after the start edge SHALL NOT affect the operation in progress.

Reset
REQ-026 resetn=0 at an edge SHALL force IDLE, idx=0, carries=0, done=0, busy=0 and result=0, taking priority over start and out_read.
REQ-027 Reset asserted during RUN or DONE SHALL abandon the operation.
REQ-028 After resetn returns to 1 the first accepted start SHALL behave as in REQ-013.

Verification
REQ-029 Defaults, in_a=1, in_b=1, add, m=BLS12-381 prime (0x1a0111ea…ffaaab) -> done exactly 6 edges after start, result=2, busy=1 throughout.
REQ-030 WIDTH=8, LIMB=4, m=251, add:
- a=200, b=100 -> 49.
- a=200, b=51 -> 0.
- a=0, b=250 -> 250.
- Each case: done after 2 edges.
REQ-031 WIDTH=8, LIMB=4, m=251, sub:
- a=10, b=20 -> 241.
- a=20, b=10 -> 10.
- a=b=77 -> 0.
REQ-032 Defaults, a=m−1, b=m−1, add -> m−2. Then:
- start pulsed during RUN and again in DONE is ignored.
- result holds for 5 idle cycles without out_read.
- out_read=1 -> done=0 next cycle and IDLE.
REQ-033 Reset and restart:
- resetn=0 at RUN idx=3 -> done=0, result=0, busy=0 next cycle.
- Then start with a=5, b=7, sub -> m−2 after 6 edges.

Source files
------------

// File: rtl/modaddsub_limb.sv
// Modular add/subtract, (a+b) mod m or (a-b) mod m, computed one LIMB-bit slice per cycle.
// Latency: NLIMBS cycles from the start edge to done; result held until out_read.
// Backpressure: start is only taken in IDLE; result/done hold in DONE until out_read=1 at an edge.
//
// Ports:
//   clk, resetn        rising-edge clock, synchronous active-low reset
//   start, subtract    launch an operation (IDLE only); 0 = add, 1 = subtract
//   in_a, in_b, in_m   operands and modulus (WIDTH bits), captured with start
//   out_read           consumer acknowledge, honoured only while done=1
//   result, done, busy reduced result, result-valid flag, RUN/DONE indicator

module modaddsub_limb #(
  parameter int WIDTH = 381,
  parameter int LIMB  = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  input  logic             out_read,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);

  localparam int NLIMBS = (WIDTH + LIMB - 1) / LIMB;
  // Operands are held zero-padded to a whole number of limbs.
  localparam int PW     = NLIMBS * LIMB;
  localparam int IW     = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;

  localparam logic [IW-1:0] LAST_IDX  = IW'(NLIMBS - 1);
  localparam logic [PW-1:0] LIMB_MASK = PW'({LIMB{1'b1}});

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Latched operation
  logic [PW-1:0] a_q, b_q, m_q;
  logic          sub_q;

  // Limb walk state: index, chain flags, partial s (a +/- b) and t (s -/+ m)
  logic [IW-1:0] idx_q;
  logic          c1_q, c2_q;
  logic [PW-1:0] s_q, t_q;

  // Current-limb datapath
  logic [31:0]   sh;
  logic [LIMB-1:0] a_l, b_l, m_l, s_l, t_l;
  logic [LIMB:0]   sum1, sum2;
  logic            c1_d, c2_d;
  logic [PW-1:0]   s_full, t_full;
  logic            last_limb;
  logic            sel_t;

  //--------------------------------------------------------------------------
  // Limb datapath: chain 1 forms s, chain 2 consumes this cycle's s limb.
  //--------------------------------------------------------------------------
  always_comb begin
    sh   = 32'(LIMB) * 32'(idx_q);
    a_l  = LIMB'(a_q >> sh);
    b_l  = LIMB'(b_q >> sh);
    m_l  = LIMB'(m_q >> sh);

    // LIMB+1 bit arithmetic: bit LIMB is the carry (add) or borrow (sub),
    // since a borrowing difference lands in [-2^LIMB, -1] and has its MSB set.
    if (!sub_q) begin
      sum1 = {1'b0, a_l} + {1'b0, b_l} + {{LIMB{1'b0}}, c1_q};
    end else begin
      sum1 = {1'b0, a_l} - {1'b0, b_l} - {{LIMB{1'b0}}, c1_q};
    end
    s_l  = sum1[LIMB-1:0];
    c1_d = sum1[LIMB];

    // Chain 2 runs the opposite operation against the modulus.
    if (!sub_q) begin
      sum2 = {1'b0, s_l} - {1'b0, m_l} - {{LIMB{1'b0}}, c2_q};
    end else begin
      sum2 = {1'b0, s_l} + {1'b0, m_l} + {{LIMB{1'b0}}, c2_q};
    end
    t_l  = sum2[LIMB-1:0];
    c2_d = sum2[LIMB];

    // Merge the fresh limbs into the stored partials so the final selection
    // sees complete s and t in the same cycle the last limb is formed.
    s_full = (s_q & ~(LIMB_MASK << sh)) | (PW'(s_l) << sh);
    t_full = (t_q & ~(LIMB_MASK << sh)) | (PW'(t_l) << sh);

    last_limb = (idx_q == LAST_IDX);

    // Add: a+b overflowed the padded width, or a+b-m did not borrow -> a+b >= m.
    // Sub: a-b borrowed -> wrap by adding m.
    if (!sub_q) begin
      sel_t = c1_d | ~c2_d;
    end else begin
      sel_t = c1_d;
    end
  end

  //--------------------------------------------------------------------------
  // FSM next state
  //--------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start)     state_d = S_RUN;
      S_RUN:  if (last_limb) state_d = S_DONE;
      S_DONE: if (out_read)  state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // State and datapath registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      c1_q    <= 1'b0;
      c2_q    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      s_q     <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q   <= PW'(in_a);
            b_q   <= PW'(in_b);
            m_q   <= PW'(in_m);
            sub_q <= subtract;
            idx_q <= '0;
            c1_q  <= 1'b0;
            c2_q  <= 1'b0;
          end
        end
        S_RUN: begin
          c1_q <= c1_d;
          c2_q <= c2_d;
          s_q  <= s_full;
          t_q  <= t_full;
          if (last_limb) begin
            idx_q  <= '0;
            done   <= 1'b1;
            result <= sel_t ? t_full[WIDTH-1:0] : s_full[WIDTH-1:0];
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        S_DONE: begin
          // result is left as-is on acknowledge; only done drops.
          if (out_read) done <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_modaddsub_limb.sv
// Bench for modaddsub_limb: a default-size instance (381/64) and a small one (8/4).
// Latency: checks done arrives exactly NLIMBS edges after the start edge.
// Backpressure: exercises result hold without out_read and start-while-busy rejection.

module tb_modaddsub_limb;

  localparam logic [380:0] P    = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
  localparam logic [380:0] P_M1 = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaaa;
  localparam logic [380:0] P_M2 = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaa9;

  logic         clk;
  logic         resetn;
  logic [1:0]   start_v;
  logic [1:0]   sub_v;
  logic [1:0]   rd_v;
  logic [380:0] in_a_v [2];
  logic [380:0] in_b_v [2];
  logic [380:0] in_m_v [2];
  logic [380:0] res_big;
  logic [7:0]   res_small;
  logic [1:0]   done_v;
  logic [1:0]   busy_v;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  modaddsub_limb dut_big (
    .clk(clk), .resetn(resetn), .start(start_v[0]), .subtract(sub_v[0]),
    .in_a(in_a_v[0]), .in_b(in_b_v[0]), .in_m(in_m_v[0]),
    .out_read(rd_v[0]), .result(res_big), .done(done_v[0]), .busy(busy_v[0])
  );

  modaddsub_limb #(.WIDTH(8), .LIMB(4)) dut_small (
    .clk(clk), .resetn(resetn), .start(start_v[1]), .subtract(sub_v[1]),
    .in_a(in_a_v[1][7:0]), .in_b(in_b_v[1][7:0]), .in_m(in_m_v[1][7:0]),
    .out_read(rd_v[1]), .result(res_small), .done(done_v[1]), .busy(busy_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nl(input int d);
    return (d == 0) ? 6 : 2;
  endfunction

  // Reference arithmetic straight from the definition of modular add/sub.
  function automatic logic [380:0] modop(input logic [380:0] a, input logic [380:0] b,
                                         input logic [380:0] m, input logic s);
    logic [381:0] x;
    if (!s) begin
      x = {1'b0, a} + {1'b0, b};
      if (x >= {1'b0, m}) x = x - {1'b0, m};
    end else if (a >= b) begin
      x = {1'b0, a} - {1'b0, b};
    end else begin
      x = {1'b0, a} + {1'b0, m} - {1'b0, b};
    end
    return x[380:0];
  endfunction

  task automatic chk(input string nm, input logic [380:0] act, input logic [380:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [380:0] res_of(input int d);
    return (d == 0) ? res_big : 381'(res_small);
  endfunction

  // Transaction-level model: phase, cycles remaining, expected outputs.
  int           mst [2];
  int           rem [2];
  logic [380:0] pend [2];
  logic [380:0] exp_res [2];
  logic         exp_done [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!resetn) begin
        mst[d] = 0; rem[d] = 0; exp_done[d] = 1'b0; exp_res[d] = '0;
      end else if (mst[d] == 0) begin
        if (start_v[d]) begin
          pend[d] = modop(in_a_v[d], in_b_v[d], in_m_v[d], sub_v[d]);
          rem[d]  = nl(d);
          mst[d]  = 1;
        end
      end else if (mst[d] == 1) begin
        rem[d] = rem[d] - 1;
        if (rem[d] == 0) begin
          mst[d] = 2; exp_done[d] = 1'b1; exp_res[d] = pend[d];
        end
      end else if (rd_v[d]) begin
        mst[d] = 0; exp_done[d] = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("dut%0d done", d), 381'(done_v[d]), 381'(exp_done[d]));
        chk($sformatf("dut%0d busy", d), 381'(busy_v[d]), 381'(mst[d] != 0));
        if (exp_done[d]) chk($sformatf("dut%0d result", d), res_of(d), exp_res[d]);
      end
    end
  end

  task automatic wait_done(input int d, input string nm);
    int lat;
    lat = 0;
    while (!done_v[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 381'(lat), 381'(nl(d)));
  endtask

  task automatic read_out(input int d, input string nm);
    @(negedge clk); rd_v[d] = 1'b1;
    @(posedge clk); #1 rd_v[d] = 1'b0;
    chk({nm, " done after read"}, 381'(done_v[d]), 381'(0));
    chk({nm, " busy after read"}, 381'(busy_v[d]), 381'(0));
  endtask

  // One full operation with a hand-computed expected result.
  task automatic run_op(input int d, input logic [380:0] a, input logic [380:0] b,
                        input logic [380:0] m, input logic s, input logic [380:0] exp,
                        input string nm);
    @(negedge clk);
    in_a_v[d] = a; in_b_v[d] = b; in_m_v[d] = m; sub_v[d] = s; start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    // Scramble inputs: the operation in flight must not see these.
    in_a_v[d] = ~a; in_b_v[d] = ~b; in_m_v[d] = ~m; sub_v[d] = ~s;
    wait_done(d, nm);
    chk({nm, " result"}, res_of(d), exp);
    read_out(d, nm);
  endtask

  initial begin
    resetn = 1'b0; start_v = '0; sub_v = '0; rd_v = '0;
    for (int d = 0; d < 2; d++) begin
      in_a_v[d] = '0; in_b_v[d] = '0; in_m_v[d] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset big result", res_big, 381'(0));
    chk("reset small result", 381'(res_small), 381'(0));
    chk("reset big busy", 381'(busy_v[0]), 381'(0));
    chk("reset small done", 381'(done_v[1]), 381'(0));
    resetn = 1'b1;
    cmp_en = 1'b1;

    // Default size: 1 + 1 mod p
    run_op(0, 381'd1, 381'd1, P, 1'b0, 381'd2, "big 1+1");

    // Small size, m = 251
    run_op(1, 381'd200, 381'd100, 381'd251, 1'b0, 381'd49,  "small 200+100");
    run_op(1, 381'd200, 381'd51,  381'd251, 1'b0, 381'd0,   "small 200+51");
    run_op(1, 381'd0,   381'd250, 381'd251, 1'b0, 381'd250, "small 0+250");
    run_op(1, 381'd10,  381'd20,  381'd251, 1'b1, 381'd241, "small 10-20");
    run_op(1, 381'd20,  381'd10,  381'd251, 1'b1, 381'd10,  "small 20-10");
    run_op(1, 381'd77,  381'd77,  381'd251, 1'b1, 381'd0,   "small 77-77");

    // Start held high across the acknowledge edge: taken only on the following edge.
    @(negedge clk);
    in_a_v[1] = 381'd9; in_b_v[1] = 381'd4; in_m_v[1] = 381'd251; sub_v[1] = 1'b1; start_v[1] = 1'b1;
    @(posedge clk); #1 start_v[1] = 1'b0;
    wait_done(1, "small 9-4");
    chk("small 9-4 result", res_of(1), 381'd5);
    @(negedge clk);
    in_a_v[1] = 381'd3; in_b_v[1] = 381'd4; sub_v[1] = 1'b0; start_v[1] = 1'b1; rd_v[1] = 1'b1;
    @(posedge clk); #1 rd_v[1] = 1'b0;
    chk("start with read busy", 381'(busy_v[1]), 381'(0));
    @(posedge clk); #1 start_v[1] = 1'b0;
    chk("start after read busy", 381'(busy_v[1]), 381'(1));
    wait_done(1, "small 3+4");
    chk("small 3+4 result", res_of(1), 381'd7);
    read_out(1, "small 3+4");

    // (p-1)+(p-1), with start pulses in RUN and DONE and a long hold.
    @(negedge clk);
    in_a_v[0] = P_M1; in_b_v[0] = P_M1; in_m_v[0] = P; sub_v[0] = 1'b0; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0; in_a_v[0] = 381'd1; in_b_v[0] = 381'd1;
    repeat (2) @(posedge clk);
    #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    begin
      int lat;
      lat = 3;
      while (!done_v[0] && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("big max latency", 381'(lat), 381'(6));
    end
    chk("big max result", res_big, P_M2);
    start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d result", i), res_big, P_M2);
      chk($sformatf("hold%0d done", i), 381'(done_v[0]), 381'(1));
    end
    @(negedge clk); rd_v[0] = 1'b1;
    @(posedge clk); #1 rd_v[0] = 1'b0;
    chk("big max done after read", 381'(done_v[0]), 381'(0));
    chk("big max result after read", res_big, P_M2);
    @(posedge clk); #1;
    chk("big max idle after read", 381'(busy_v[0]), 381'(0));

    // Reset in the middle of RUN (idx = 3), then restart.
    @(negedge clk);
    in_a_v[0] = 381'd7; in_b_v[0] = 381'd8; in_m_v[0] = P; sub_v[0] = 1'b0; start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk); #1;
    chk("midrun reset done", 381'(done_v[0]), 381'(0));
    chk("midrun reset result", res_big, 381'(0));
    chk("midrun reset busy", 381'(busy_v[0]), 381'(0));
    resetn = 1'b1;
    run_op(0, 381'd5, 381'd7, P, 1'b1, P_M2, "big 5-7");

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
